// File: rtl/traffic_pkg.sv
// traffic_pkg: phase state encoding and lamp helpers shared by the traffic FSM,
// the phase scheduler and the lamp driver.
package traffic_pkg;
    localparam int NUM_DIR = 4;

    typedef enum logic [1:0] {
        ST_ALL_RED = 2'd0,
        ST_GREEN   = 2'd1,
        ST_YELLOW  = 2'd2
    } state_t;

    function automatic logic [NUM_DIR-1:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction
endpackage

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: combinational 4-way round-robin pick; priority starts at last+1
// and wraps, so last itself is served only when nobody else asks.
module rr_arbiter4 (
    input  logic [4:1] req,
    input  logic [1:0] last,
    output logic       valid,
    output logic [1:0] winner
);
    logic [3:0] r;
    logic [1:0] idx;

    assign r     = req;
    assign valid = |r;

    // Walk from lowest to highest priority so the nearest requester is assigned last.
    always_comb begin
        winner = last;
        idx    = '0;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (r[idx]) winner = idx;
        end
    end
endmodule

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: round-robin GREEN -> YELLOW -> ALL_RED sequencer for a 4-approach
// intersection. Define EMERGENCY_PREEMPT_EN to add the emerg[4:1] preemption input.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN = 5,
    parameter int MAX_GREEN = 20,
    parameter int YELLOW    = 3,
    parameter int ALL_RED   = 2,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:1] sensors,
`ifdef EMERGENCY_PREEMPT_EN
    input  logic [4:1] emerg,
`endif
    output logic [4:1] green,
    output logic [4:1] yellow,
    output logic [4:1] red,
    output logic [1:0] phase
);
    localparam logic [CNT_W-1:0] MIN_LIM = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_LIM = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_LIM = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] AR_LIM  = CNT_W'(ALL_RED - 1);

    state_t           state, state_n;
    logic [1:0]       last, last_n, winner, e;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       req, pending, grant, own, lamp_n;
    logic             valid, others, emerg_any, preempt, hold;

    assign req    = {sensors[8] | sensors[7], sensors[6] | sensors[5],
                     sensors[4] | sensors[3], sensors[2] | sensors[1]};
    assign own    = onehot4(last);
    assign others = |(pending & ~own);
    assign phase  = last;

`ifdef EMERGENCY_PREEMPT_EN
    assign emerg_any = |emerg;
    assign e         = emerg[1] ? 2'd0 : emerg[2] ? 2'd1 : emerg[3] ? 2'd2 : 2'd3;
`else
    assign emerg_any = 1'b0;
    assign e         = 2'd0;
`endif
    assign preempt = emerg_any && (e != last);
    assign hold    = emerg_any && (e == last);

    rr_arbiter4 u_arb (
        .req    (pending | req),
        .last   (last),
        .valid  (valid),
        .winner (winner)
    );

    always_comb begin
        state_n = state;
        last_n  = last;
        grant   = '0;
        if (state == ST_ALL_RED) begin
            if (cnt >= AR_LIM && (valid || emerg_any)) begin
                state_n = ST_GREEN;
                last_n  = emerg_any ? e : winner;
                grant   = onehot4(last_n);
            end
        end else if (state == ST_GREEN) begin
            grant = own;
            if (preempt || (!hold && others && cnt >= MIN_LIM && (!req[last] || cnt == MAX_LIM)))
                state_n = ST_YELLOW;
        end else if (cnt >= YEL_LIM) begin
            state_n = ST_ALL_RED;
        end
    end

    assign lamp_n = (state_n == ST_ALL_RED) ? 4'b0000 : onehot4(last_n);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_ALL_RED;
            cnt     <= '0;
            pending <= '0;
            last    <= 2'd3;
            green   <= '0;
            yellow  <= '0;
            red     <= 4'b1111;
        end else begin
            state   <= state_n;
            last    <= last_n;
            cnt     <= (state_n != state) ? '0 : (cnt == MAX_LIM) ? cnt : cnt + CNT_W'(1);
            pending <= (pending | req) & ~grant;
            green   <= (state_n == ST_GREEN) ? lamp_n : 4'b0000;
            yellow  <= (state_n == ST_YELLOW) ? lamp_n : 4'b0000;
            red     <= ~lamp_n;
        end
    end
endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb_traffic_phase_scheduler: scoreboarded check of lamp/phase outputs, one expected
// {green,yellow,red,phase} entry per clock queued by the stimulus and popped by a monitor.
module tb_traffic_phase_scheduler;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:1] sensors = '0;
    logic [4:1] green, yellow, red;
    logic [1:0] phase;
`ifdef EMERGENCY_PREEMPT_EN
    logic [4:1] emerg = '0;
`endif

    typedef struct {
        string       tag;
        logic [13:0] v;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    traffic_phase_scheduler dut (
        .clk     (clk),
        .rst     (rst),
        .sensors (sensors),
`ifdef EMERGENCY_PREEMPT_EN
        .emerg   (emerg),
`endif
        .green   (green),
        .yellow  (yellow),
        .red     (red),
        .phase   (phase)
    );

    task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got g/y/r/ph=%b_%b_%b_%b expected %b_%b_%b_%b", tag,
                     got[13:10], got[9:6], got[5:2], got[1:0],
                     exp[13:10], exp[9:6], exp[5:2], exp[1:0]);
        end
    endtask

    // Queue the expected outputs for the next n edges; red is always the complement of green|yellow.
    task automatic run(input int n, input logic [3:0] g, input logic [3:0] y,
                       input logic [1:0] ph, input string tag);
        exp_t e;
        repeat (n) begin
            @(posedge clk);
            #1;
            e.tag = tag;
            e.v   = {g, y, ~(g | y), ph};
            sb.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check(mon_e.tag, {green, yellow, red, phase}, mon_e.v);
        end
    end

    initial begin
        // reset and idle with no demand
        run(1, 4'b0000, 4'b0000, 2'd3, "reset");
        rst = 1'b0;
        run(4, 4'b0000, 4'b0000, 2'd3, "idle");

        // held demand on approaches 1 and 2: max-out, then hand over to 2
        rst = 1'b1;
        run(1, 4'b0000, 4'b0000, 2'd3, "s2_reset");
        rst = 1'b0;
        sensors = 8'b0000_1010;
        run(1,  4'b0000, 4'b0000, 2'd3, "s2_allred");
        run(20, 4'b0001, 4'b0000, 2'd0, "s2_green1");
        run(3,  4'b0000, 4'b0001, 2'd0, "s2_yellow1");
        run(2,  4'b0000, 4'b0000, 2'd0, "s2_red1");
        run(1,  4'b0010, 4'b0000, 2'd1, "s2_green2");

        // reset mid-green, then gap-out on approach 3 with approach 4 waiting
        rst = 1'b1;
        run(1, 4'b0000, 4'b0000, 2'd3, "rst_green");
        rst = 1'b0;
        sensors = 8'b0101_0000;
        run(1, 4'b0000, 4'b0000, 2'd3, "s3_allred");
        run(3, 4'b0100, 4'b0000, 2'd2, "s3_green");
        sensors = 8'b0100_0000;
        run(2, 4'b0100, 4'b0000, 2'd2, "s3_gap");
        run(3, 4'b0000, 4'b0100, 2'd2, "s3_yellow");
        run(2, 4'b0000, 4'b0000, 2'd2, "s3_red");
        run(5, 4'b1000, 4'b0000, 2'd3, "s3_green4");

        // rest on approach 2, then skip 3 and 1 to serve 4
        rst = 1'b1;
        run(1, 4'b0000, 4'b0000, 2'd3, "s4_reset");
        rst = 1'b0;
        sensors = 8'b0000_0100;
        run(1,  4'b0000, 4'b0000, 2'd3, "s4_allred");
        run(25, 4'b0010, 4'b0000, 2'd1, "s4_rest");
        sensors = 8'b1000_0000;
        run(1,  4'b0010, 4'b0000, 2'd1, "s4_lastgreen");
        run(3,  4'b0000, 4'b0010, 2'd1, "s4_yellow");
        run(2,  4'b0000, 4'b0000, 2'd1, "s4_red");
        run(6,  4'b1000, 4'b0000, 2'd3, "s4_skip");

        // reset during yellow cycle 1 must also drop the pending request of approach 1
        sensors = 8'b0000_0001;
        run(1, 4'b1000, 4'b0000, 2'd3, "s5_green");
        run(2, 4'b0000, 4'b1000, 2'd3, "s5_yellow");
        rst = 1'b1;
        sensors = '0;
        run(1, 4'b0000, 4'b0000, 2'd3, "s5_rst");
        rst = 1'b0;
        run(6, 4'b0000, 4'b0000, 2'd3, "s5_idle");

`ifdef EMERGENCY_PREEMPT_EN
        rst = 1'b1;
        run(1, 4'b0000, 4'b0000, 2'd3, "e_reset");
        rst = 1'b0;
        sensors = 8'b0000_0001;
        run(1,  4'b0000, 4'b0000, 2'd3, "e_allred");
        run(2,  4'b0001, 4'b0000, 2'd0, "e_green1");
        emerg = 4'b0100;
        run(3,  4'b0000, 4'b0001, 2'd0, "e_yellow1");
        run(2,  4'b0000, 4'b0000, 2'd0, "e_red1");
        run(25, 4'b0100, 4'b0000, 2'd2, "e_hold");
        emerg = 4'b0000;
        run(3,  4'b0000, 4'b0100, 2'd2, "e_yellow3");
        run(2,  4'b0000, 4'b0000, 2'd2, "e_red3");
        run(1,  4'b0001, 4'b0000, 2'd0, "e_resume");
`endif

        repeat (3) @(negedge clk);
        #1;
        check("drain", 14'(sb.size()), 14'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
